// File: rtl/alarm_pkg.sv
// Shared types and helpers for the alarm-clock mode controller.
// Holds the controller state encoding, field limits and BCD conversion.
package alarm_pkg;

    typedef enum logic [2:0] {
        CLOCK  = 3'd0,
        SET_TH = 3'd1,
        SET_TM = 3'd2,
        SET_AH = 3'd3,
        SET_AM = 3'd4,
        RING   = 3'd5
    } mode_t;

    localparam int MAX_HOUR = 23;
    localparam int MAX_MIN  = 59;

    // Converts a two-digit BCD value (tens 0-5/0-2, units 0-9) to binary.
    function automatic logic [6:0] bcd_to_bin(input logic [2:0] tens, input logic [3:0] units);
        return ({4'd0, tens} * 7'd10) + {3'd0, units};
    endfunction

endpackage

// File: rtl/wrap_field.sv
// Loadable up/down modulo counter used for the edit hours and edit minutes.
// Priority: load, then increment, then decrement; wraps between 0 and MAX.
module wrap_field #(
    parameter int WIDTH = 6,
    parameter int MAX   = 59
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_value,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] value
);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value <= '0;
        end else if (ld) begin
            value <= ld_value;
        end else if (inc) begin
            value <= (value == WIDTH'(MAX)) ? '0 : value + WIDTH'(1);
        end else if (dec) begin
            value <= (value == '0) ? WIDTH'(MAX) : value - WIDTH'(1);
        end
    end

endmodule

// File: rtl/alarm_mode_controller.sv
// Mode/sequencing controller: time-set and alarm-set sequences, counter preload
// handshake and alarm ringing with a tick-based auto-silence timeout.
module alarm_mode_controller
    import alarm_pkg::*;
#(
    parameter int RING_SECS = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       btn_c,
    input  logic       btn_u,
    input  logic       btn_d,
    input  logic       btn_l,
    input  logic       btn_r,
    input  logic [3:0] cur_sec_units,
    input  logic [3:0] cur_min_units,
    input  logic [3:0] cur_hour_units,
    input  logic [2:0] cur_sec_tens,
    input  logic [2:0] cur_min_tens,
    input  logic [2:0] cur_hour_tens,
    output logic       counter_enable,
    output logic       load,
    output logic [5:0] time_minutes,
    output logic [4:0] time_hours,
    output logic [5:0] disp_minutes,
    output logic [4:0] disp_hours,
    output logic [2:0] mode,
    output logic       alarm_on,
    output logic       buzzer
);

    localparam int CW = (RING_SECS > 1) ? $clog2(RING_SECS) : 1;
    localparam logic [CW-1:0] RING_LAST = CW'(RING_SECS - 1);

    mode_t state, next_state;

    logic win_c, win_u, win_d, win_l, win_r, any_btn;
    logic [6:0] cur_h7, cur_m7;
    logic [4:0] alarm_h, edit_h;
    logic [5:0] alarm_m, edit_m;
    logic m, m_q, m_rise;
    logic [CW-1:0] ring_cnt;
    logic edit_ld, edit_from_time, h_inc, h_dec, m_inc, m_dec;
    logic commit_time, commit_alarm, toggle_arm, ring_clear, ring_inc;

    // Fixed priority c > u > d > l > r: only one button is ever acted on.
    assign win_c   = btn_c;
    assign win_u   = btn_u & ~btn_c;
    assign win_d   = btn_d & ~btn_c & ~btn_u;
    assign win_l   = btn_l & ~(btn_c | btn_u | btn_d);
    assign win_r   = btn_r & ~(btn_c | btn_u | btn_d | btn_l);
    assign any_btn = btn_c | btn_u | btn_d | btn_l | btn_r;

    assign cur_h7 = bcd_to_bin(cur_hour_tens, cur_hour_units);
    assign cur_m7 = bcd_to_bin(cur_min_tens, cur_min_units);

    assign m = alarm_on && (cur_h7 == {2'd0, alarm_h}) && (cur_m7 == {1'd0, alarm_m})
               && (cur_sec_tens == 3'd0) && (cur_sec_units == 4'd0);
    assign m_rise = m & ~m_q;

    wrap_field #(.WIDTH(5), .MAX(MAX_HOUR)) u_edit_hours (
        .clk      (clk),
        .reset    (reset),
        .ld       (edit_ld),
        .ld_value (edit_from_time ? cur_h7[4:0] : alarm_h),
        .inc      (h_inc),
        .dec      (h_dec),
        .value    (edit_h)
    );

    wrap_field #(.WIDTH(6), .MAX(MAX_MIN)) u_edit_minutes (
        .clk      (clk),
        .reset    (reset),
        .ld       (edit_ld),
        .ld_value (edit_from_time ? cur_m7[5:0] : alarm_m),
        .inc      (m_inc),
        .dec      (m_dec),
        .value    (edit_m)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= CLOCK;
        else        state <= next_state;
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        next_state     = state;
        edit_ld        = 1'b0;
        edit_from_time = 1'b0;
        h_inc          = 1'b0;
        h_dec          = 1'b0;
        m_inc          = 1'b0;
        m_dec          = 1'b0;
        commit_time    = 1'b0;
        commit_alarm   = 1'b0;
        toggle_arm     = 1'b0;
        ring_clear     = 1'b0;
        ring_inc       = 1'b0;
        case (state)
            CLOCK: begin
                if (m_rise) begin
                    next_state = RING;
                    ring_clear = 1'b1;
                end else if (win_c) begin
                    if (!load) begin
                        next_state     = SET_TH;
                        edit_ld        = 1'b1;
                        edit_from_time = 1'b1;
                    end
                end else if (win_d) begin
                    toggle_arm = 1'b1;
                end else if (win_r) begin
                    next_state = SET_AH;
                    edit_ld    = 1'b1;
                end
            end
            SET_TH, SET_AH: begin
                if (win_c) begin
                    next_state   = CLOCK;
                    commit_time  = (state == SET_TH);
                    commit_alarm = (state == SET_AH);
                end else if (win_u) begin
                    h_inc = 1'b1;
                end else if (win_d) begin
                    h_dec = 1'b1;
                end else if (win_l || win_r) begin
                    next_state = (state == SET_TH) ? SET_TM : SET_AM;
                end
            end
            SET_TM, SET_AM: begin
                if (win_c) begin
                    next_state   = CLOCK;
                    commit_time  = (state == SET_TM);
                    commit_alarm = (state == SET_AM);
                end else if (win_u) begin
                    m_inc = 1'b1;
                end else if (win_d) begin
                    m_dec = 1'b1;
                end else if (win_l || win_r) begin
                    next_state = (state == SET_TM) ? SET_TH : SET_AH;
                end
            end
            RING: begin
                if (any_btn) begin
                    next_state = CLOCK;
                end else if (tick) begin
                    if (ring_cnt == RING_LAST) next_state = CLOCK;
                    else                       ring_inc   = 1'b1;
                end
            end
            default: next_state = CLOCK;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            load         <= 1'b0;
            time_hours   <= '0;
            time_minutes <= '0;
            alarm_h      <= '0;
            alarm_m      <= '0;
            alarm_on     <= 1'b0;
            m_q          <= 1'b0;
            ring_cnt     <= '0;
        end else begin
            m_q <= m;
            // load holds through the first tick it sees so the counter chain can catch it.
            if (commit_time) begin
                time_hours   <= edit_h;
                time_minutes <= edit_m;
                load         <= 1'b1;
            end else if (load && tick) begin
                load <= 1'b0;
            end
            if (commit_alarm) begin
                alarm_h <= edit_h;
                alarm_m <= edit_m;
            end
            if (toggle_arm) alarm_on <= ~alarm_on;
            if (ring_clear)    ring_cnt <= '0;
            else if (ring_inc) ring_cnt <= ring_cnt + CW'(1);
        end
    end

    assign mode           = state;
    assign counter_enable = !((state == SET_TH) || (state == SET_TM));
    assign buzzer         = (state == RING);
    assign disp_hours     = (state inside {SET_TH, SET_TM, SET_AH, SET_AM}) ? edit_h : '0;
    assign disp_minutes   = (state inside {SET_TH, SET_TM, SET_AH, SET_AM}) ? edit_m : '0;

endmodule

// File: tb/tb_alarm_mode_controller.sv
// Directed self-checking bench for alarm_mode_controller with a 3-tick ring timeout.
module tb_alarm_mode_controller;
    import alarm_pkg::*;

    localparam logic [4:0] C = 5'b10000, U = 5'b01000, D = 5'b00100, L = 5'b00010, R = 5'b00001;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic tick = 1'b0;
    logic btn_c = 1'b0, btn_u = 1'b0, btn_d = 1'b0, btn_l = 1'b0, btn_r = 1'b0;
    logic [3:0] cur_sec_units, cur_min_units, cur_hour_units;
    logic [2:0] cur_sec_tens, cur_min_tens, cur_hour_tens;
    logic       counter_enable, load, alarm_on, buzzer;
    logic [5:0] time_minutes, disp_minutes;
    logic [4:0] time_hours, disp_hours;
    logic [2:0] mode;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alarm_mode_controller #(.RING_SECS(3)) dut (
        .clk            (clk),
        .reset          (reset),
        .tick           (tick),
        .btn_c          (btn_c),
        .btn_u          (btn_u),
        .btn_d          (btn_d),
        .btn_l          (btn_l),
        .btn_r          (btn_r),
        .cur_sec_units  (cur_sec_units),
        .cur_min_units  (cur_min_units),
        .cur_hour_units (cur_hour_units),
        .cur_sec_tens   (cur_sec_tens),
        .cur_min_tens   (cur_min_tens),
        .cur_hour_tens  (cur_hour_tens),
        .counter_enable (counter_enable),
        .load           (load),
        .time_minutes   (time_minutes),
        .time_hours     (time_hours),
        .disp_minutes   (disp_minutes),
        .disp_hours     (disp_hours),
        .mode           (mode),
        .alarm_on       (alarm_on),
        .buzzer         (buzzer)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [4:0] b);
        {btn_c, btn_u, btn_d, btn_l, btn_r} = b;
        cycle();
        {btn_c, btn_u, btn_d, btn_l, btn_r} = 5'b0;
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        cycle();
        tick = 1'b0;
    endtask

    task automatic set_time(input int h, input int mi, input int s);
        cur_hour_tens  = 3'(h / 10);
        cur_hour_units = 4'(h % 10);
        cur_min_tens   = 3'(mi / 10);
        cur_min_units  = 4'(mi % 10);
        cur_sec_tens   = 3'(s / 10);
        cur_sec_units  = 4'(s % 10);
    endtask

    initial begin
        set_time(12, 34, 56);
        #7;
        check("rst_mode", mode, CLOCK);
        check("rst_enable", counter_enable, 1);
        check("rst_load", load, 0);
        check("rst_buzzer", buzzer, 0);
        check("rst_alarm_on", alarm_on, 0);
        check("rst_time", {time_hours, time_minutes}, 0);
        check("rst_disp", {disp_hours, disp_minutes}, 0);
        @(negedge clk);
        reset = 1'b1;
        cycle();

        // Time set 12:34 -> 13:59
        press(C);
        check("th_mode", mode, SET_TH);
        check("th_enable", counter_enable, 0);
        check("th_copy_h", disp_hours, 12);
        check("th_copy_m", disp_minutes, 34);
        press(U);
        check("th_inc", disp_hours, 13);
        press(R);
        check("tm_mode", mode, SET_TM);
        repeat (35) press(D);
        check("tm_dec35", disp_minutes, 59);
        check("tm_enable", counter_enable, 0);
        press(C);
        check("commit_mode", mode, CLOCK);
        check("commit_load", load, 1);
        check("commit_th", time_hours, 13);
        check("commit_tm", time_minutes, 59);
        check("commit_enable", counter_enable, 1);
        check("commit_disp", disp_hours, 0);
        cycle();
        check("load_hold", load, 1);
        press(C);
        check("c_ignored_in_load", mode, CLOCK);
        tick = 1'b1;
        check("load_in_tick", load, 1);
        cycle();
        tick = 1'b0;
        check("load_falls", load, 0);
        check("time_stable", time_hours, 13);

        // Wrap and priority checks
        set_time(23, 0, 0);
        press(C);
        check("wrap_copy_h", disp_hours, 23);
        press(U);
        check("wrap_h_up", disp_hours, 0);
        press(U | D);
        check("prio_u_over_d", disp_hours, 1);
        press(L);
        check("l_to_tm", mode, SET_TM);
        check("wrap_copy_m", disp_minutes, 0);
        press(D);
        check("wrap_m_down", disp_minutes, 59);
        press(C | U);
        check("cu_commit_mode", mode, CLOCK);
        check("cu_commit_m", time_minutes, 59);
        check("cu_commit_h", time_hours, 1);
        check("cu_commit_load", load, 1);
        pulse_tick();
        check("cu_load_falls", load, 0);

        // Alarm set 06:30 and arm
        press(R);
        check("ah_mode", mode, SET_AH);
        check("ah_copy", {disp_hours, disp_minutes}, 0);
        repeat (6) press(U);
        press(R);
        check("am_mode", mode, SET_AM);
        repeat (30) press(U);
        check("am_value", disp_minutes, 30);
        press(C);
        check("alarm_commit_mode", mode, CLOCK);
        check("alarm_commit_noload", load, 0);
        check("alarm_not_armed", alarm_on, 0);
        press(D);
        check("arm", alarm_on, 1);
        press(R);
        check("alarm_reg_h", disp_hours, 6);
        check("alarm_reg_m", disp_minutes, 30);
        press(C);
        check("alarm_recommit", mode, CLOCK);

        // Match while editing time must not ring
        set_time(6, 29, 59);
        cycle();
        press(C);
        set_time(6, 30, 0);
        cycle();
        cycle();
        check("match_in_th_mode", mode, SET_TH);
        check("match_in_th_buzz", buzzer, 0);
        press(C);
        cycle();
        check("no_late_ring", mode, CLOCK);
        check("no_late_buzz", buzzer, 0);
        pulse_tick();

        // Ring with timeout
        set_time(6, 29, 59);
        cycle();
        set_time(6, 30, 0);
        check("pre_ring_mode", mode, CLOCK);
        cycle();
        check("ring_mode", mode, RING);
        check("ring_buzz", buzzer, 1);
        set_time(6, 30, 1);
        pulse_tick();
        check("ring_tick1", buzzer, 1);
        cycle();
        pulse_tick();
        check("ring_tick2", buzzer, 1);
        pulse_tick();
        check("ring_timeout", buzzer, 0);
        check("ring_timeout_mode", mode, CLOCK);
        check("ring_keeps_arm", alarm_on, 1);

        // Ring silenced by button after two ticks
        set_time(6, 30, 0);
        cycle();
        check("ring2_mode", mode, RING);
        pulse_tick();
        pulse_tick();
        set_time(6, 30, 1);
        press(U);
        check("btn_exit_mode", mode, CLOCK);
        check("btn_exit_buzz", buzzer, 0);
        check("btn_exit_arm", alarm_on, 1);

        // Ring counter restarts on entry; d in RING does not disarm
        cycle();
        set_time(6, 30, 0);
        cycle();
        check("ring3_mode", mode, RING);
        pulse_tick();
        check("ring_cnt_cleared", buzzer, 1);
        press(D);
        check("d_exit_mode", mode, CLOCK);
        check("d_exit_arm", alarm_on, 1);

        // Asynchronous reset mid-ring
        set_time(6, 30, 1);
        cycle();
        set_time(6, 30, 0);
        cycle();
        check("ring4_buzz", buzzer, 1);
        #2 reset = 1'b0;
        #1;
        check("async_rst_buzz", buzzer, 0);
        check("async_rst_arm", alarm_on, 0);
        check("async_rst_mode", mode, CLOCK);
        reset = 1'b1;
        cycle();

        // Asynchronous reset mid-load
        press(C);
        press(C);
        check("load_before_rst", load, 1);
        #2 reset = 1'b0;
        #1;
        check("async_rst_load", load, 0);
        check("async_rst_time", time_hours, 0);
        reset = 1'b1;
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/alarm_mode_controller.md
# alarm_mode_controller

Mode/sequencing controller for the alarm-clock datapath. It interprets five pre-debounced buttons and runs the time-set and alarm-set sequences. It drives the time counter's `enable`, `load`, `time_minutes` and `time_hours` inputs, holds the alarm setting, and raises the buzzer when the running time reaches the armed alarm time. It sits between the button debouncers and the seconds/minutes/hours counter chain, in the fast `clk` domain.

## Interface
Parameters:
- `RING_SECS`, 60: buzzer auto-silence timeout, in `tick` pulses.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-low reset.
- `tick` in 1: one-cycle pulse per second, synchronous to `clk`.
- `btn_c`, `btn_u`, `btn_d`, `btn_l`, `btn_r` in 1 each: one-cycle debounced press pulses.
- `cur_sec_units`, `cur_min_units`, `cur_hour_units` in 4 each: running-time BCD units digits.
- `cur_sec_tens`, `cur_min_tens`, `cur_hour_tens` in 3 each: running-time BCD tens digits.
- `counter_enable` out 1: counter run enable.
- `load` out 1: counter preload request.
- `time_minutes` out 6: preload minutes, binary 0–59.
- `time_hours` out 5: preload hours, binary 0–23.
- `disp_minutes` out 6: value shown in set modes, binary.
- `disp_hours` out 5: value shown in set modes, binary.
- `mode` out 3: current state encoding.
- `alarm_on` out 1: alarm armed.
- `buzzer` out 1: alarm ringing.

## Operation
- States: CLOCK, SET_TH, SET_TM, SET_AH, SET_AM, RING.
- Button priority when several pulse in one cycle: c > u > d > l > r. Only the winner is acted on.
- CLOCK:
  - `btn_c` (ignored while `load`=1) → SET_TH; edit registers copy the current time (tens*10+units).
  - `btn_r` → SET_AH; edit registers copy the alarm registers.
  - `btn_d` toggles `alarm_on`.
- SET_TH / SET_AH: `btn_u` increments edit hours, 23→0 wrap. `btn_d` decrements, 0→23 wrap. `btn_l` or `btn_r` moves to the matching minutes state.
- SET_TM / SET_AM: `btn_u`/`btn_d` change edit minutes mod 60, 59↔0 wrap. `btn_l` or `btn_r` moves to the matching hours state.
- Commit with `btn_c` in any set state, then → CLOCK:
  - Time states: `time_hours`/`time_minutes` take the edit values and `load` is raised.
  - Alarm states: the alarm registers take the edit values; no load.
- `load` is stretched:
  - Rises the cycle after commit.
  - Stays high through the first `tick` cycle seen while high, then falls on the next cycle.
  - `time_*` stay stable for the whole time `load` is high.
- `counter_enable` = 0 in SET_TH/SET_TM, otherwise 1. Time freezes while it is being edited.
- Alarm match condition, `m`: `alarm_on` and current hh:mm = alarm hh:mm and seconds = 00.
  - `m` is registered into `m_q`.
  - A rising edge (`m` & !`m_q`) while in CLOCK → RING.
  - A match in any other state is ignored and does not ring later.
- RING:
  - `buzzer`=1.
  - Any button pulse → CLOCK; the pulse is not otherwise acted on.
  - After `RING_SECS` ticks → CLOCK.
  - `alarm_on` is unchanged.
- `disp_*` show the edit registers in set states and 0 otherwise.

## Timing
- Reset values:
  - State CLOCK, so `mode` = CLOCK encoding.
  - `counter_enable`=1.
  - `load`=0, `time_*`=0, `disp_*`=0.
  - Alarm registers 00:00, `alarm_on`=0, `buzzer`=0.
  - Edit registers 0, ring counter 0, `m_q`=0.
- Button to state change or edit register update: 1 cycle.
- `counter_enable` is decoded from the state register: it drops the cycle after `btn_c` in CLOCK.
- Commit at cycle N:
  - `load`=1 from N+1.
  - State is CLOCK at N+1.
- RING entered 1 cycle after the rising edge of `m`.
- Buzzer timeout: `buzzer` falls the cycle after the `RING_SECS`-th tick counted in RING. The ring counter clears on RING entry.
- Reset asserted mid-ring or mid-load: `buzzer` and `load` go low immediately (asynchronous).

## Structure
- Shared package `alarm_pkg` holds:
  - The state enum.
  - `MAX_HOUR`=23 and `MAX_MIN`=59.
  - The BCD-digit-to-binary conversion function.
- Sub-module `wrap_field #(WIDTH, MAX)` is natural here: a loadable up/down modulo field register. Instantiate it twice, for edit hours and edit minutes.

## Test plan
- Reset → `mode`=CLOCK, `counter_enable`=1, `load`=0, `buzzer`=0, `alarm_on`=0.
- Current time 12:34; press c, u, r, d×35, c → `time_hours`=13, `time_minutes`=59. `load` stays high until one tick after commit. `counter_enable`=0 while editing.
- Wrap checks:
  - SET_TH at 23, press u → 0.
  - SET_TM at 0, press d → 59.
- Set alarm 06:30 via r, u×6, r, u×30, c, then d to arm. Drive current time 06:29:59 → 06:30:00: RING the next cycle and `buzzer`=1. With `RING_SECS`=3, `buzzer` is low after the 3rd tick.
- In RING, press u → CLOCK; `buzzer` low next cycle; `alarm_on` still 1.
- Same cycle `btn_c`+`btn_u` in SET_TM → commit only, edit value unchanged. Alarm match during SET_TH → no RING.
